// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE TCDM gather unit.
// Lane geometry and gather FSM state encoding.
package redmule_pkg;

    localparam int unsigned LANE_W  = 32;
    localparam int unsigned LANE_BE = LANE_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } redmule_gather_state_e;

endpackage

// File: rtl/redmule_gather_lane.sv
// One narrow TCDM lane: grant flag, response flag, response buffer.
// Flags clear per transaction; the buffer survives soft clear.
module redmule_gather_lane
    import redmule_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              set_gnt_i,
    input  logic              set_rv_i,
    input  logic [LANE_W-1:0] data_i,
    output logic              gnt_o,
    output logic              rv_o,
    output logic [LANE_W-1:0] buf_o
);

    logic              gnt_q, gnt_d;
    logic              rv_q, rv_d;
    logic [LANE_W-1:0] buf_q, buf_d;

    always_comb begin
        gnt_d = gnt_q;
        rv_d  = rv_q;
        buf_d = buf_q;
        if (clr_i) begin
            gnt_d = 1'b0;
            rv_d  = 1'b0;
        end else begin
            if (set_gnt_i) gnt_d = 1'b1;
            if (set_rv_i) begin
                rv_d  = 1'b1;
                buf_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q <= 1'b0;
            rv_q  <= 1'b0;
            buf_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            rv_q  <= rv_d;
            buf_q <= buf_d;
        end
    end

    assign gnt_o = gnt_q;
    assign rv_o  = rv_q;
    assign buf_o = buf_q;

endmodule

// File: rtl/redmule_tcdm_gather.sv
// Splits one wide streamer access into MP narrow TCDM accesses
// and gathers the narrow responses back into one wide response.
module redmule_tcdm_gather
    import redmule_pkg::*;
#(
    parameter int unsigned MP = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          wide_req_i,
    output logic                          wide_gnt_o,
    input  logic [31:0]                   wide_add_i,
    input  logic                          wide_wen_i,
    input  logic [MP*LANE_BE-1:0]         wide_be_i,
    input  logic [MP*LANE_W-1:0]          wide_data_i,
    output logic                          wide_r_valid_o,
    output logic [MP*LANE_W-1:0]          wide_r_data_o,
    output logic [MP-1:0]                 tcdm_req_o,
    input  logic [MP-1:0]                 tcdm_gnt_i,
    output logic [MP-1:0][31:0]           tcdm_add_o,
    output logic [MP-1:0]                 tcdm_wen_o,
    output logic [MP-1:0][LANE_BE-1:0]    tcdm_be_o,
    output logic [MP-1:0][LANE_W-1:0]     tcdm_data_o,
    input  logic [MP-1:0][LANE_W-1:0]     tcdm_r_data_i,
    input  logic [MP-1:0]                 tcdm_r_valid_i,
    output logic                          busy_o,
    output logic                          err_o
);

    redmule_gather_state_e state_q, state_d;

    logic [31:0]          add_q, add_d;
    logic                 wen_q, wen_d;
    logic [MP*LANE_BE-1:0] be_q, be_d;
    logic [MP*LANE_W-1:0] data_q, data_d;
    logic                 err_q, err_d;

    logic [MP-1:0]             gnt_m, rv_m;
    logic [MP-1:0]             set_gnt, set_rv;
    logic [MP-1:0][LANE_W-1:0] bufs;
    logic                      accept, issue, collect;
    logic                      all_gnt, all_rv;

    assign issue   = (state_q == ISSUE);
    assign collect = (state_q == ISSUE) || (state_q == WAIT);
    assign accept  = rst_ni && !clear_i && wide_req_i && (state_q == IDLE);

    assign tcdm_req_o = issue ? ~gnt_m : '0;
    assign set_gnt    = clear_i ? '0 : (tcdm_req_o & tcdm_gnt_i);
    assign set_rv     = (collect && !clear_i) ?
                        (tcdm_r_valid_i & gnt_m & ~rv_m) : '0;

    assign all_gnt = &(gnt_m | set_gnt);
    assign all_rv  = &(rv_m | set_rv);

    assign wide_gnt_o     = accept;
    assign wide_r_valid_o = (state_q == RESP);
    assign wide_r_data_o  = bufs;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;

    for (genvar i = 0; i < MP; i++) begin : g_lane
        assign tcdm_add_o[i]  = add_q + 32'(i * 4);
        assign tcdm_wen_o[i]  = wen_q;
        assign tcdm_be_o[i]   = be_q[i*LANE_BE +: LANE_BE];
        assign tcdm_data_o[i] = data_q[i*LANE_W +: LANE_W];

        redmule_gather_lane u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clr_i     (clear_i | accept),
            .set_gnt_i (set_gnt[i]),
            .set_rv_i  (set_rv[i]),
            .data_i    (tcdm_r_data_i[i]),
            .gnt_o     (gnt_m[i]),
            .rv_o      (rv_m[i]),
            .buf_o     (bufs[i])
        );
    end

    always_comb begin
        state_d = state_q;
        add_d   = add_q;
        wen_d   = wen_q;
        be_d    = be_q;
        data_d  = data_q;
        // any response not consumed by a lane is a protocol violation
        err_d   = err_q | (|(tcdm_r_valid_i & ~set_rv));
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    add_d   = wide_add_i;
                    wen_d   = wide_wen_i;
                    be_d    = wide_be_i;
                    data_d  = wide_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (all_rv) state_d = RESP;
                else if (all_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (all_rv) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            add_q   <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            wen_q   <= wen_d;
            be_q    <= be_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/redmule_tcdm_gather.md
REDMULE_TCDM_GATHER -- requirements
Module: redmule_tcdm_gather

Interface
REQ-001 SHALL have parameter MP, default 4, giving the number of 32-bit TCDM ports (1..16).
REQ-002 SHALL have port clk_i  in  1  the single clock; reset is asynchronous and active-low.
REQ-003 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port clear_i  in  1  synchronous soft clear.
REQ-005 SHALL have ports wide_req_i in 1, wide_gnt_o out 1, wide_add_i in 32, wide_wen_i in 1, wide_be_i in MP*4, wide_data_i in MP*32: the wide request from the streamer (wen=1 means read).
REQ-006 SHALL have ports wide_r_valid_o out 1 and wide_r_data_o out MP*32: the wide response.
REQ-007 SHALL have ports tcdm_req_o out MP, tcdm_gnt_i in MP, tcdm_add_o out MPx32, tcdm_wen_o out MP, tcdm_be_o out MPx4, tcdm_data_o out MPx32: the narrow request ports.
REQ-008 SHALL have ports tcdm_r_data_i in MPx32 and tcdm_r_valid_i in MP: the narrow responses.
REQ-009 SHALL have ports busy_o out 1 (high when state is not IDLE) and err_o out 1 (sticky protocol error).

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE, WAIT, RESP.
REQ-011 IDLE: wide_gnt_o=wide_req_i (combinational); on accept, SHALL latch add/wen/be/data, clear the gnt_mask and rv_mask, and go to ISSUE.
REQ-012 ISSUE: SHALL drive tcdm_req_o[i]=!gnt_mask[i], tcdm_add_o[i]=add_q+4*i (modulo 2^32), with be/data taken from slice i of the latched be/data (lane i = bits [32i+31:32i]).
REQ-013 Port i SHALL hold its request stable until granted; tcdm_gnt_i[i]&&tcdm_req_o[i] SHALL set gnt_mask[i], and port i SHALL NOT re-request in the same transaction.
REQ-014 SHALL go from ISSUE to WAIT in the cycle where (gnt_mask|granted-this-cycle) is all ones; if all ports are granted in the first ISSUE cycle, ISSUE lasts exactly 1 cycle.
REQ-015 In ISSUE or WAIT, tcdm_r_valid_i[i] with gnt_mask[i]=1 and rv_mask[i]=0 SHALL capture tcdm_r_data_i[i] into lane buffer i and set rv_mask[i]; responses arriving at different cycles are supported.
REQ-016 SHALL go to RESP the cycle after rv_mask becomes all ones; this applies from ISSUE or WAIT.
REQ-017 RESP: SHALL drive wide_r_valid_o=1 for exactly one cycle with wide_r_data_o=lane buffers, then go to IDLE; this holds for both reads and writes, and data is meaningful for reads only.
REQ-018 SHALL keep wide_gnt_o=0 outside IDLE; no new request is accepted in RESP, so the minimum issue interval is 4 cycles.
REQ-019 Minimum latency SHALL be: accept at cycle 0, ISSUE at 1, all r_valid at 2, wide_r_valid_o at 3.
REQ-020 tcdm_r_valid_i[i] in IDLE/RESP, for an ungranted port, or a duplicate on a port with rv_mask[i]=1, SHALL be ignored and SHALL set err_o.
REQ-021 wide_r_data_o SHALL hold the last buffered value outside RESP; tcdm_req_o SHALL be 0 outside ISSUE.
REQ-022 clear_i SHALL take priority over all events: next state IDLE, masks cleared, err_o cleared, lane buffers kept; an in-flight transaction is discarded with no wide_r_valid_o.

Reset
REQ-023 rst_ni low SHALL set asynchronously: state IDLE, gnt_mask=0, rv_mask=0, lane buffers=0, latched request=0, err_o=0.
REQ-024 During reset, all outputs SHALL be 0: tcdm_req_o, wide_gnt_o, wide_r_valid_o, busy_o, err_o, wide_r_data_o.

Structure
REQ-025 The state enum redmule_gather_state_e SHALL reside in redmule_pkg.
REQ-026 Lane registers SHALL be in one sub-module, redmule_gather_lane (gnt flag, rv flag, 32-bit buffer), instantiated MP times.
REQ-027 The implementation SHALL be 120-400 lines of RTL with no latches; all flops SHALL be on clk_i/rst_ni.

Verification
REQ-028 MP=4, read add=0x1000, all gnt/r_valid ideal -> tcdm_add_o=0x1000/1004/1008/100C, wide_r_valid_o at cycle 3, data={lane3..lane0}.
REQ-029 gnt staggered: port0 at cycle 1, port2 at 2, ports 1/3 at 4 -> each port requests exactly until granted, WAIT entered at cycle 4, one wide_r_valid_o.
REQ-030 r_valid skewed: port3 responds 3 cycles after the others -> RESP the cycle after port3, correct data on all lanes.
REQ-031 write be=0xF0F0 data=0xDEADBEEF_... -> tcdm_be_o=0x0/0xF/0x0/0xF, tcdm_wen_o=0, wide_r_valid_o after all acks.
REQ-032 add=0xFFFFFFF8 -> tcdm_add_o=0xFFFFFFF8/0xFFFFFFFC/0x0/0x4.
REQ-033 clear_i asserted in WAIT, then a stray r_valid in IDLE -> no wide_r_valid_o, state IDLE, err_o=1 after the stray response.
